// File: rtl/arbitro_escrita_banco_pkg.sv
// Shared constants and types for the register-bank writeback arbiter.
package arbitro_escrita_banco_pkg;

  localparam int unsigned NUM_REG      = 32;
  localparam int unsigned LARGURA_DADO = 32;
  localparam int unsigned LARGURA_END  = 5;
  localparam int unsigned LARGURA_CONT = 16;
  localparam int unsigned REG_ZERO     = 0;

  localparam logic [0:0] ID_ULA = 1'b0;
  localparam logic [0:0] ID_MEM = 1'b1;

  typedef enum logic {
    OCIOSO  = 1'b0,
    ESCRITA = 1'b1
  } estado_t;

  typedef struct packed {
    logic [LARGURA_END-1:0]  registrador;
    logic [LARGURA_DADO-1:0] dado;
  } pedido_t;

  // Register zero is hardwired; writes to it are swallowed.
  function automatic logic registrador_valido(input logic [LARGURA_END-1:0] r);
    return r != LARGURA_END'(REG_ZERO);
  endfunction

endpackage

// File: rtl/arbitro_escrita_banco_rr.sv
// Two-requester round-robin decision: one-hot grant from valids and last winner.
module arbitro_rr_2
  import arbitro_escrita_banco_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic [0:0] ultimo_i,
  output logic [1:0] grant_c
);

  always_comb begin
    grant_c = 2'b00;
    unique case (valid_i)
      2'b01:   grant_c[ID_ULA] = 1'b1;
      2'b10:   grant_c[ID_MEM] = 1'b1;
      2'b11: begin
        // Under contention the requester that did not win last goes next.
        if (ultimo_i == ID_ULA) grant_c[ID_MEM] = 1'b1;
        else                    grant_c[ID_ULA] = 1'b1;
      end
      default: grant_c = 2'b00;
    endcase
  end

endmodule

// File: rtl/arbitro_escrita_banco.sv
// Writeback arbiter: merges ULA and memory-load results into one register-bank
// write port with round-robin fairness, write counter and read-hazard flags.
module arbitro_escrita_banco
  import arbitro_escrita_banco_pkg::*;
#(
  parameter int unsigned PRIORIDADE_INICIAL = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_ula_valid,
  input  logic [LARGURA_END-1:0]  req_ula_reg,
  input  logic [LARGURA_DADO-1:0] req_ula_data,
  output logic                    req_ula_ready,
  input  logic                    req_mem_valid,
  input  logic [LARGURA_END-1:0]  req_mem_reg,
  input  logic [LARGURA_DADO-1:0] req_mem_data,
  output logic                    req_mem_ready,
  output logic                    we,
  output logic [LARGURA_END-1:0]  writeRegistrador,
  output logic [LARGURA_DADO-1:0] writeData,
  input  logic [LARGURA_END-1:0]  registrador1,
  input  logic [LARGURA_END-1:0]  registrador2,
  output logic                    conflito1,
  output logic                    conflito2,
  output logic [LARGURA_CONT-1:0] cont_escritas
);

  estado_t                 estado_q, estado_d;
  logic [LARGURA_END-1:0]  wreg_q, wreg_d;
  logic [LARGURA_DADO-1:0] wdata_q, wdata_d;
  logic [LARGURA_CONT-1:0] cont_q, cont_d;
  logic [0:0]              ultimo_q, ultimo_d;

  logic [1:0] valid_c;
  logic [1:0] grant_c;
  logic       transfer_c;
  logic       escreve_c;
  pedido_t    sel_c;

  // No request can be accepted while reset is held.
  assign valid_c = reset ? 2'b00 : {req_mem_valid, req_ula_valid};

  arbitro_rr_2 u_rr (
    .valid_i  (valid_c),
    .ultimo_i (ultimo_q),
    .grant_c  (grant_c)
  );

  assign req_ula_ready = grant_c[ID_ULA];
  assign req_mem_ready = grant_c[ID_MEM];
  assign transfer_c    = |grant_c;
  assign sel_c         = grant_c[ID_MEM] ? {req_mem_reg, req_mem_data}
                                         : {req_ula_reg, req_ula_data};
  assign escreve_c     = transfer_c && registrador_valido(sel_c.registrador);

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= OCIOSO;
      wreg_q   <= '0;
      wdata_q  <= '0;
      cont_q   <= '0;
      ultimo_q <= ~1'(PRIORIDADE_INICIAL);
    end else begin
      estado_q <= estado_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
      cont_q   <= cont_d;
      ultimo_q <= ultimo_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    wreg_d   = wreg_q;
    wdata_d  = wdata_q;
    cont_d   = cont_q;
    ultimo_d = ultimo_q;

    if (transfer_c) begin
      wreg_d   = sel_c.registrador;
      wdata_d  = sel_c.dado;
      ultimo_d = grant_c[ID_MEM] ? ID_MEM : ID_ULA;
    end

    unique case (estado_q)
      OCIOSO: begin
        if (escreve_c) estado_d = ESCRITA;
      end
      ESCRITA: begin
        cont_d = cont_q + LARGURA_CONT'(1);
        if (!escreve_c) estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  assign we               = (estado_q == ESCRITA);
  assign writeRegistrador = wreg_q;
  assign writeData        = wdata_q;
  assign cont_escritas    = cont_q;

  // A read address collides with anything pending or being written this cycle.
  assign conflito1 = registrador_valido(registrador1) &&
                     ((req_ula_valid && registrador1 == req_ula_reg) ||
                      (req_mem_valid && registrador1 == req_mem_reg) ||
                      (we            && registrador1 == wreg_q));
  assign conflito2 = registrador_valido(registrador2) &&
                     ((req_ula_valid && registrador2 == req_ula_reg) ||
                      (req_mem_valid && registrador2 == req_mem_reg) ||
                      (we            && registrador2 == wreg_q));

endmodule
